// File: rtl/clock_pkg.sv
// Shared definitions for the clock block: field encodings, BCD limits, reset time.
// Latency: n/a (types, constants and a combinational BCD step helper).
// Backpressure: n/a.
package clock_pkg;

  // Field being edited. Encoding 3 is unreachable in normal operation.
  typedef enum logic [1:0] {
    FLD_SEC  = 2'd0,
    FLD_MIN  = 2'd1,
    FLD_HOUR = 2'd2,
    FLD_BAD  = 2'd3
  } field_e;

  // Two-digit BCD upper limits for each field.
  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  // Reset time 23:57:00, shared with the time counter.
  localparam logic [7:0] RST_HOUR = 8'h23;
  localparam logic [7:0] RST_MIN  = 8'h57;
  localparam logic [7:0] RST_SEC  = 8'h00;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } bcd_time_t;

  // One BCD step up or down with wrap at max_bcd. A value that is not a legal
  // field value (bad low digit or above the limit) is clamped to 00 instead.
  function automatic logic [7:0] bcd_step(input logic [7:0] v,
                                          input logic [7:0] max_bcd,
                                          input logic       down);
    logic [3:0] hi;
    logic [3:0] lo;
    logic [7:0] r;
    hi = v[7:4];
    lo = v[3:0];
    if (lo > 4'd9 || v > max_bcd) begin
      r = 8'h00;
    end else if (!down) begin
      if (v == max_bcd)    r = 8'h00;
      else if (lo == 4'd9) r = {hi + 4'd1, 4'd0};
      else                 r = {hi, lo + 4'd1};
    end else begin
      if (v == 8'h00)      r = max_bcd;
      else if (lo == 4'd0) r = {hi - 4'd1, 4'd9};
      else                 r = {hi, lo - 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw button -> 2-FF synchronizer -> debounced level + one-cycle press pulse.
// Latency: 2 + DEB_CYCLES cycles from raw edge to level change; press is combinational on the new level.
// Backpressure: none. Ports: clk, rst (sync, high), key (raw), level (debounced), press (rising-edge pulse).
module key_debounce #(
  parameter int DEB_CYCLES = 20,
  parameter int CNT_W      = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level_q;
  logic             armed;
  logic [CNT_W-1:0] cnt;

  // After reset the key is disarmed: the synchronized input must be seen low
  // for DEB_CYCLES consecutive samples before a press can be accepted, so a
  // button held through reset has to be released and pressed again.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      armed   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= key;
      sync2   <= sync1;
      level_q <= level;
      if (!armed) begin
        level <= 1'b0;
        if (sync2) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt   <= '0;
          armed <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/manual_time_set.sv
// Manual time editor: debounced sel/inc/dec keys edit a BCD time snapshotted on set-mode entry.
// Latency: raw press to digit change 2 + DEB_CYCLES + 1 cycles; snapshot on the set_active rising edge.
// Backpressure: none; key pulses outside set mode are dropped.
// Ports: div_clk, rst (sync, high), sw0/sw1 mode, key_sel/inc/dec raw, self_* running time in,
//        manual_* edited time out, sel_field (0 sec, 1 min, 2 hour), set_active.
module manual_time_set
  import clock_pkg::*;
#(
  parameter int DEB_CYCLES   = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int CNT_W        = 10
) (
  input  logic       div_clk,
  input  logic       rst,
  input  logic       sw0,
  input  logic       sw1,
  input  logic       key_sel,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic [3:0] self_secL,
  input  logic [3:0] self_secH,
  input  logic [3:0] self_minL,
  input  logic [3:0] self_minH,
  input  logic [3:0] self_hourL,
  input  logic [3:0] self_hourH,
  output logic [3:0] manual_secL,
  output logic [3:0] manual_secH,
  output logic [3:0] manual_minL,
  output logic [3:0] manual_minH,
  output logic [3:0] manual_hourL,
  output logic [3:0] manual_hourH,
  output logic [1:0] sel_field,
  output logic       set_active
);

  localparam logic [CNT_W-1:0] REP_FIRE   = CNT_W'(REPEAT_DELAY);
  // Reloading to DELAY-RATE+1 makes the next match land exactly RATE cycles later.
  localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_RATE + 1);

  logic sel_lvl, sel_press;
  logic inc_lvl, inc_press;
  logic dec_lvl, dec_press;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_sel (
    .clk(div_clk), .rst(rst), .key(key_sel), .level(sel_lvl), .press(sel_press)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_inc (
    .clk(div_clk), .rst(rst), .key(key_inc), .level(inc_lvl), .press(inc_press)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_dec (
    .clk(div_clk), .rst(rst), .key(key_dec), .level(dec_lvl), .press(dec_press)
  );

  // Auto-repeat: counters run from 0 in the press cycle while the level is high.
  logic [CNT_W-1:0] inc_rep, dec_rep;
  logic             inc_fire, dec_fire;
  logic             inc_evt, dec_evt;

  assign inc_fire = inc_lvl && (inc_rep == REP_FIRE);
  assign dec_fire = dec_lvl && (dec_rep == REP_FIRE);
  assign inc_evt  = inc_press | inc_fire;
  assign dec_evt  = dec_press | dec_fire;

  always_ff @(posedge div_clk) begin
    if (rst || !inc_lvl) inc_rep <= '0;
    else if (inc_fire)   inc_rep <= REP_RELOAD;
    else                 inc_rep <= inc_rep + 1'b1;

    if (rst || !dec_lvl) dec_rep <= '0;
    else if (dec_fire)   dec_rep <= REP_RELOAD;
    else                 dec_rep <= dec_rep + 1'b1;
  end

  // Mode tracking and entry detection.
  logic mode_now;
  logic entry;
  logic edit;

  assign mode_now = !sw0 && sw1;
  assign entry    = mode_now && !set_active;
  // Coincident inc and dec cancel.
  assign edit     = set_active && (inc_evt ^ dec_evt);

  always_ff @(posedge div_clk) begin
    if (rst) set_active <= 1'b0;
    else     set_active <= mode_now;
  end

  // Field-select FSM: state register.
  field_e fld_q, fld_d;

  always_ff @(posedge div_clk) begin
    if (rst) fld_q <= FLD_SEC;
    else     fld_q <= fld_d;
  end

  // Field-select FSM: next state. Entry overrides any sel pulse.
  always_comb begin
    fld_d = fld_q;
    if (entry) begin
      fld_d = FLD_SEC;
    end else begin
      case (fld_q)
        FLD_SEC:  if (set_active && sel_press) fld_d = FLD_MIN;
        FLD_MIN:  if (set_active && sel_press) fld_d = FLD_HOUR;
        FLD_HOUR: if (set_active && sel_press) fld_d = FLD_SEC;
        default:  fld_d = FLD_SEC;
      endcase
    end
  end

  // Field-select FSM: output.
  always_comb begin
    sel_field = fld_q;
  end

  // Time register. Edits use the field selected before any same-cycle sel.
  bcd_time_t time_q, time_d;

  always_comb begin
    time_d = time_q;
    if (entry) begin
      time_d.hour = {self_hourH, self_hourL};
      time_d.min  = {self_minH,  self_minL};
      time_d.sec  = {self_secH,  self_secL};
    end else if (edit) begin
      case (fld_q)
        FLD_SEC:  time_d.sec  = bcd_step(time_q.sec,  SEC_MAX,  dec_evt);
        FLD_MIN:  time_d.min  = bcd_step(time_q.min,  MIN_MAX,  dec_evt);
        FLD_HOUR: time_d.hour = bcd_step(time_q.hour, HOUR_MAX, dec_evt);
        default:  time_d = time_q;
      endcase
    end
  end

  always_ff @(posedge div_clk) begin
    if (rst) begin
      time_q.hour <= RST_HOUR;
      time_q.min  <= RST_MIN;
      time_q.sec  <= RST_SEC;
    end else begin
      time_q <= time_d;
    end
  end

  assign manual_hourH = time_q.hour[7:4];
  assign manual_hourL = time_q.hour[3:0];
  assign manual_minH  = time_q.min[7:4];
  assign manual_minL  = time_q.min[3:0];
  assign manual_secH  = time_q.sec[7:4];
  assign manual_secL  = time_q.sec[3:0];

endmodule

// File: tb/tb_manual_time_set.sv
// Bench for manual_time_set: directed and random key presses against a decimal reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_manual_time_set;

  localparam int DEB  = 4;
  localparam int DLY  = 10;
  localparam int RATE = 3;

  logic        div_clk = 1'b0;
  logic        rst, sw0, sw1, key_sel, key_inc, key_dec;
  logic [23:0] self_t;
  logic [3:0]  m_secL, m_secH, m_minL, m_minH, m_hourL, m_hourH;
  logic [1:0]  sel_field;
  logic        set_active;
  logic [23:0] man;

  always #5 div_clk = ~div_clk;

  manual_time_set #(
    .DEB_CYCLES(DEB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .CNT_W(10)
  ) dut (
    .div_clk(div_clk), .rst(rst), .sw0(sw0), .sw1(sw1),
    .key_sel(key_sel), .key_inc(key_inc), .key_dec(key_dec),
    .self_secL(self_t[3:0]),    .self_secH(self_t[7:4]),
    .self_minL(self_t[11:8]),   .self_minH(self_t[15:12]),
    .self_hourL(self_t[19:16]), .self_hourH(self_t[23:20]),
    .manual_secL(m_secL),   .manual_secH(m_secH),
    .manual_minL(m_minL),   .manual_minH(m_minH),
    .manual_hourL(m_hourL), .manual_hourH(m_hourH),
    .sel_field(sel_field), .set_active(set_active)
  );

  assign man = {m_hourH, m_hourL, m_minH, m_minL, m_secH, m_secL};

  int          checks   = 0;
  int          failures = 0;
  logic [23:0] exp_t;
  int          exp_fld;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge div_clk);
  endtask

  // Number of inc/dec pulses produced by a key held for h raw cycles.
  function automatic int npulses(input int h);
    if (h < DEB) return 0;
    if (h <= DLY) return 1;
    return 2 + (h - 1 - DLY) / RATE;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Apply n inc (or dec) steps to field fld of time t using decimal modulo arithmetic.
  function automatic logic [23:0] model(input logic [23:0] t, input int fld,
                                        input int n, input bit down);
    logic [23:0] r;
    logic [7:0]  f;
    int          hi, lo, v, md;
    r  = t;
    f  = t[fld*8 +: 8];
    md = (fld == 2) ? 24 : 60;
    hi = int'(f[7:4]);
    lo = int'(f[3:0]);
    v  = hi * 10 + lo;
    for (int i = 0; i < n; i++) begin
      if (i == 0 && (lo > 9 || v >= md)) v = 0;
      else if (down)                     v = (v + md - 1) % md;
      else                               v = (v + 1) % md;
    end
    if (n > 0) r[fld*8 +: 8] = to_bcd(v);
    return r;
  endfunction

  function automatic logic [23:0] rand_time();
    logic [23:0] t;
    int          d;
    t = {to_bcd(int'($urandom % 24)), to_bcd(int'($urandom % 60)), to_bcd(int'($urandom % 60))};
    if ($urandom % 6 == 0) begin
      d = int'($urandom % 6);
      t[d*4 +: 4] = 4'(10 + $urandom % 6);
    end
    return t;
  endfunction

  task automatic press(input bit s, input bit i, input bit d, input int h);
    key_sel = s; key_inc = i; key_dec = d;
    cyc(h);
    key_sel = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
    cyc(14);
  endtask

  task automatic enter(input logic [23:0] s);
    sw0 = 1'b0; sw1 = 1'b0;
    cyc(3);
    chk("hold_after_exit", man, exp_t);
    chk("inactive", 32'(set_active), 32'd0);
    self_t = s;
    sw1 = 1'b1;
    cyc(2);
    chk("active", 32'(set_active), 32'd1);
    chk("snapshot", man, s);
    chk("snap_field", 32'(sel_field), 32'd0);
    self_t = rand_time();   // later changes of self must not leak in
    exp_t = s;
    exp_fld = 0;
  endtask

  // kind: 0 inc, 1 dec, 2 inc+dec together, 3 sel+inc together (single pulse)
  task automatic run_case(input logic [23:0] s, input int nsel, input int kind, input int h);
    enter(s);
    for (int k = 0; k < nsel; k++) begin
      press(1'b1, 1'b0, 1'b0, 6);
      exp_fld = (exp_fld + 1) % 3;
      chk("sel_step", 32'(sel_field), 32'(exp_fld));
    end
    case (kind)
      0: begin press(1'b0, 1'b1, 1'b0, h); exp_t = model(exp_t, exp_fld, npulses(h), 1'b0); end
      1: begin press(1'b0, 1'b0, 1'b1, h); exp_t = model(exp_t, exp_fld, npulses(h), 1'b1); end
      2: begin press(1'b0, 1'b1, 1'b1, h); end
      default: begin
        press(1'b1, 1'b1, 1'b0, 6);
        exp_t = model(exp_t, exp_fld, 1, 1'b0);
        exp_fld = (exp_fld + 1) % 3;
      end
    endcase
    chk("edit_value", man, exp_t);
    chk("edit_field", 32'(sel_field), 32'(exp_fld));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sw0 = 1'b1; sw1 = 1'b0;
    key_sel = 1'b0; key_inc = 1'b1; key_dec = 1'b0;
    self_t = 24'h000000;
    cyc(1);
    key_inc = 1'b0;
    cyc(1);
    key_inc = 1'b1;
    cyc(1);
    rst = 1'b0; key_inc = 1'b0;
    exp_t = 24'h235700;
    exp_fld = 0;
    chk("rst_time", man, exp_t);
    chk("rst_field", 32'(sel_field), 32'd0);
    chk("rst_active", 32'(set_active), 32'd0);
    cyc(20);
    chk("rst_hold", man, exp_t);

    enter(24'h123456);

    // Bounce too short to debounce, then the exact press latency.
    enter(24'h123459);
    press(1'b0, 1'b1, 1'b0, 2);
    chk("bounce", man, 24'h123459);
    key_inc = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc(1);
      if (k == 6) begin
        key_inc = 1'b0;
        chk("lat_pre", man, 24'h123459);
      end
      if (k == 7) chk("lat_edge", man, 24'h123400);
    end
    exp_t = 24'h123400;
    cyc(14);
    chk("lat_settled", man, exp_t);

    run_case(24'h003015, 2, 1, 6);    // hour 00 - 1 -> 23
    run_case(24'h194011, 2, 0, 6);    // hour 19 + 1 -> 20
    run_case(24'h125700, 1, 0, 25);   // min 57 held: 58,59,00,01,02,03
    run_case(24'h123456, 0, 2, 6);    // inc+dec cancel
    run_case(24'h123456, 1, 2, 25);   // cancel through repeats
    run_case(24'h123409, 0, 3, 6);    // sel+inc: sec 09 -> 10, field -> MIN
    run_case(24'h123A00, 1, 0, 6);    // bad min clamps to 00
    run_case(24'h12A400, 1, 1, 25);   // clamp then five decrements
    run_case(24'h235959, 0, 0, 14);   // sec wraps, no carry out

    // Alarm mode and auto mode: keys must not edit.
    sw1 = 1'b0;
    cyc(3);
    chk("alarm_inactive", 32'(set_active), 32'd0);
    press(1'b0, 1'b1, 1'b0, 6);
    chk("alarm_hold", man, exp_t);
    sw0 = 1'b1;
    press(1'b1, 1'b0, 1'b1, 6);
    chk("auto_hold", man, exp_t);
    chk("auto_field", 32'(sel_field), 32'(exp_fld));

    for (int it = 0; it < 30; it++) begin
      run_case(rand_time(), int'($urandom % 3), int'($urandom % 4), int'($urandom_range(1, 30)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/manual_time_set.md
Name: manual_time_set

Overview:
- Upstream feeder for the self-clocking time counter: produces the manual_secL..manual_hourH BCD digits that the counter loads while in time-set mode (sw0=0, sw1=1).
- Debounces three raw push-buttons (select / increment / decrement).
- Steps a field-select state machine and edits the selected field with BCD wrap and hold-to-auto-repeat.
- On entry to set mode, snapshots the running time so editing starts from the current value.

Parameters:
- DEB_CYCLES, 20, consecutive stable samples required to accept a key level change.
- REPEAT_DELAY, 500, held cycles after the first inc/dec pulse before auto-repeat starts.
- REPEAT_RATE, 100, cycles between auto-repeat pulses while held.
- CNT_W, 10, width of the debounce and repeat counters; must hold max(DEB_CYCLES, REPEAT_DELAY).

Ports:
- div_clk  in  1  divided scan clock (nominal 1 kHz); only clock.
- rst  in  1  synchronous, active-high reset.
- sw0  in  1  mode switch; 1 = auto count.
- sw1  in  1  with sw0=0: 1 = time-set mode, 0 = alarm-set mode.
- key_sel  in  1  raw button, active-high, asynchronous to div_clk.
- key_inc  in  1  raw button, active-high.
- key_dec  in  1  raw button, active-high.
- self_secL, self_secH, self_minL, self_minH, self_hourL, self_hourH  in  4 each  current running time (BCD).
- manual_secL, manual_secH, manual_minL, manual_minH, manual_hourL, manual_hourH  out  4 each  edited time (BCD).
- sel_field  out  2  0 = SEC, 1 = MIN, 2 = HOUR; for display blinking.
- set_active  out  1  registered (sw0==0 && sw1==1).

Behaviour:
- Reset (rst=1 at a div_clk edge):
  - manual digits = 23:57:00 (hourH=2, hourL=3, minH=5, minL=7, secH=0, secL=0), matching the counter reset.
  - sel_field = SEC; set_active = 0.
  - All debounce and repeat counters = 0; debounced key levels = 0.
  - Reset during a held key: the key must be released and re-debounced before it acts again.
- Input sync: each raw key passes through a 2-FF synchronizer, then the debouncer.
- Debounce: the debounced level changes only after DEB_CYCLES consecutive samples differ from it. Press pulse = rising edge of the debounced level, 1 cycle wide.
- Total latency, raw press to digit change: 2 (sync) + DEB_CYCLES + 1 cycles.
- Auto-repeat (inc/dec only):
  - While the debounced level stays high, emit an extra pulse REPEAT_DELAY cycles after the press pulse.
  - Then one pulse every REPEAT_RATE cycles.
  - The repeat counter clears on release.
- Entry snapshot:
  - set_active is registered each cycle.
  - In the cycle where set_active goes 0->1, copy the self_* digits into the manual regs and force sel_field = SEC.
  - The snapshot has priority over any key pulse in that cycle; that pulse is dropped.
- Editing happens only while set_active=1. Key pulses are ignored otherwise and the manual regs hold.
- Field FSM: SEC -> MIN -> HOUR -> SEC on each sel pulse. Encoding 3 is unreachable and recovers to SEC on the next cycle.
- Inc/dec arithmetic:
  - SEC and MIN are 2-digit BCD mod 60: 59+1 -> 00, 00-1 -> 59. The low digit carries/borrows into the high digit: 09+1 -> 10, 10-1 -> 09.
  - HOUR is mod 24: 23+1 -> 00, 00-1 -> 23, 19+1 -> 20.
  - Only the selected field changes. No carry into other fields.
- Simultaneous events:
  - inc and dec pulses in the same cycle: no change.
  - sel together with inc/dec: the edit applies to the old field, then sel_field advances.
- Out-of-range BCD in a snapshot (e.g. minL=0xA): the next inc/dec on that field first clamps it to 00, with no other effect.
- Leaving set mode: the manual regs hold their last value (the counter has already loaded them continuously).

Decomposition:
- Shared package clock_pkg:
  - field encodings FLD_SEC=2'd0, FLD_MIN=2'd1, FLD_HOUR=2'd2;
  - BCD limits SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23;
  - reset time constants RST_HOUR=23, RST_MIN=57, RST_SEC=00, shared with the counter.
- Sub-module key_debounce (params DEB_CYCLES, CNT_W): synchronizer + debouncer + press pulse. Instantiated 3 times.
- Auto-repeat logic, FSM and BCD editing stay in the top module.

Test Plan (DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3):
- rst high 2 cycles -> manual = 23:57:00, sel_field=0, set_active=0. Raw key_inc toggled during reset -> no change after release.
- self = 12:34:56, then sw0=0, sw1=1 -> one cycle after set_active rises, manual = 12:34:56 and sel_field=0.
- sec=59 in set mode, key_inc held 2 cycles then released (bounce) -> no change. Held 6 cycles -> sec = 00, min unchanged (34), exactly 7 cycles after the raw rise.
- sel pressed twice -> sel_field=2. dec from hour 00 -> 23. inc from 19 -> 20.
- key_inc held 25 cycles on MIN=57 -> pulses at press, +10, +13, +16, +19, +22 cycles -> 58, 59, 00, 01, 02, 03.
- inc and dec pulses coincident -> digits unchanged. sw1=0 (alarm mode) with inc pressed -> manual unchanged, set_active=0.
